dm_slave: RTL

DM_SLAVE -- requirements
Module: dm_slave

---
 rtl/dm_slave_pkg.sv | 21 ++
 rtl/dm_slave_mem_array.sv | 26 ++
 rtl/dm_slave.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dm_slave_pkg.sv
// Shared definitions for the dm_slave data-memory model: bus widths,
// FSM state encodings and the latency-counter load helper.
package dm_slave_pkg;

    localparam int DM_ADDR_WIDTH = 32;
    localparam int DM_DATA_WIDTH = 32;
    localparam int DM_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        DMS_IDLE = 2'd0,
        DMS_WAIT = 2'd1,
        DMS_DONE = 2'd2
    } dms_state_e;

    // Counter value loaded on entry to WAIT: the IDLE cycle and the last
    // WAIT cycle (counter at 0) each account for one stall cycle.
    function automatic logic [DM_CNT_WIDTH-1:0] cnt_load(input int latency);
        return (latency > 1) ? DM_CNT_WIDTH'(latency - 2) : '0;
    endfunction

endpackage

// File: rtl/dm_slave_mem_array.sv
// Word storage for dm_slave: one combinational read port, one synchronous
// write port, no reset (contents survive RST).
module dm_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  CLK,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Write port: commit one word per enabled rising edge.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dm_slave.sv
// dm_slave: data-memory slave with optional multi-cycle stall handshake.
// Build option: define DM_SLAVE_STALL_EN to get the IDLE/WAIT/DONE FSM with
// LATENCY stall cycles per access; otherwise the memory answers reads
// combinationally and writes on the clock edge with no stall.
module dm_slave
    import dm_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DM_REQ,
    input  logic                  DM_WEN,
    input  logic [ADDR_WIDTH-1:0] DM_addr,
    input  logic [DATA_WIDTH-1:0] DM_wdata,
    output logic [DATA_WIDTH-1:0] DM_rdata,
    output logic                  DM_stall
);

    // Word index: byte-offset bits and bits above the index are dropped,
    // so out-of-range addresses wrap onto the array.
    logic [DEPTH_LOG2-1:0] live_idx;
    logic                  unused_addr;
    assign live_idx    = DM_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^DM_addr;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_en;
    logic                  stall;

    dm_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .CLK     (CLK),
        .we_i    (mem_we),
        .waddr_i (mem_addr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata)
    );

`ifdef DM_SLAVE_STALL_EN
    localparam logic [DM_CNT_WIDTH-1:0] CNT_LOAD = cnt_load(LATENCY);

    dms_state_e              state_q, state_d;
    logic [DM_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    // State, counter and latched request; reset drops any pending access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= DMS_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, stall and memory-port control for the access handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        stall     = 1'b0;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = idx_q;
        mem_wdata = wdata_q;
        case (state_q)
            DMS_IDLE: begin
                if (DM_REQ) begin
                    if (LATENCY == 0) begin
                        // Zero latency: serve the live request directly.
                        mem_addr  = live_idx;
                        mem_wdata = DM_wdata;
                        mem_we    = DM_WEN;
                        rd_en     = ~DM_WEN;
                    end else begin
                        stall   = 1'b1;
                        idx_d   = live_idx;
                        wen_d   = DM_WEN;
                        wdata_d = DM_wdata;
                        if (LATENCY == 1) begin
                            state_d = DMS_DONE;
                        end else begin
                            state_d = DMS_WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            end
            DMS_WAIT: begin
                if (!DM_REQ) begin
                    state_d = DMS_IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DMS_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DMS_DONE: begin
                state_d = DMS_IDLE;
                // A dropped request here aborts: nothing is written.
                if (DM_REQ) begin
                    rd_en  = 1'b1;
                    mem_we = wen_q;
                end
            end
            default: state_d = DMS_IDLE;
        endcase
        if (RST) begin
            mem_we = 1'b0;
        end
    end
`else
    // Stall-free path: live address, combinational read, edge write.
    always_comb begin
        stall     = 1'b0;
        mem_addr  = live_idx;
        mem_wdata = DM_wdata;
        mem_we    = DM_REQ & DM_WEN & ~RST;
        rd_en     = DM_REQ & ~DM_WEN;
    end
`endif

    assign DM_stall = stall & ~RST;
    assign DM_rdata = (rd_en & ~RST) ? mem_rdata : '0;

endmodule
